// File: rtl/stream_rr_arbiter_pkg.sv
// Shared types and helpers for the round-robin stream arbiter.
//   stage_state_t : occupancy of the two-entry registered output stage
//   rr_pick       : circular first-one search starting just after a pointer
package stream_arb_pkg;

  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    BUSY  = 2'd1,
    FULL  = 2'd2
  } stage_state_t;

  localparam int unsigned MaxInputs = 16;

  // Returns the first set index of req[n-1:0] searching ptr+1, ptr+2, ... modulo n.
  // Returns 0 when req is empty; callers qualify the result with |req.
  function automatic logic [3:0] rr_pick(input logic [15:0] req, input logic [3:0] ptr,
                                         input int unsigned n);
    logic        found;
    int unsigned k;
    rr_pick = '0;
    found   = 1'b0;
    for (int unsigned i = 1; i <= MaxInputs; i++) begin
      k = (32'(ptr) + i) % n;
      if ((i <= n) && !found && req[k]) begin
        rr_pick = k[3:0];
        found   = 1'b1;
      end
    end
  endfunction

endpackage

// File: rtl/stream_rr_arbiter_if.sv
// Handshake bundle between NUM_INPUTS upstream requesters, the arbiter and one
// downstream consumer.
//   i_valid/i_data/i_last : per-requester beat offered upstream
//   i_ready               : per-requester acceptance (at most one bit high)
//   o_valid/o_data/o_source/o_last, o_ready : downstream stream
// Modports: slave = arbiter side, master = requester/consumer side.
interface stream_rr_arbiter_if #(
  parameter int NUM_INPUTS = 4,
  parameter int WORD_WIDTH = 8,
  parameter int SRC_WIDTH  = $clog2(NUM_INPUTS)
);
  logic [NUM_INPUTS-1:0]            i_valid;
  logic [NUM_INPUTS-1:0]            i_ready;
  logic [NUM_INPUTS*WORD_WIDTH-1:0] i_data;
  logic [NUM_INPUTS-1:0]            i_last;
  logic                             o_valid;
  logic                             o_ready;
  logic [WORD_WIDTH-1:0]            o_data;
  logic [SRC_WIDTH-1:0]             o_source;
  logic                             o_last;

  modport slave (
    input  i_valid, i_data, i_last, o_ready,
    output i_ready, o_valid, o_data, o_source, o_last
  );

  modport master (
    output i_valid, i_data, i_last, o_ready,
    input  i_ready, o_valid, o_data, o_source, o_last
  );
endinterface

// File: rtl/stream_rr_arbiter_rr_grant.sv
// Combinational circular priority picker.
//   req_i   : request vector
//   ptr_i   : index granted last; search starts at ptr_i+1
//   grant_o : one-hot grant (all zero when no request)
//   idx_o   : index of the granted requester
//   any_o   : at least one request present
module rr_grant
  import stream_arb_pkg::*;
#(
  parameter int NUM_INPUTS = 4,
  parameter int SRC_WIDTH  = $clog2(NUM_INPUTS)
) (
  input  logic [NUM_INPUTS-1:0] req_i,
  input  logic [SRC_WIDTH-1:0]  ptr_i,
  output logic [NUM_INPUTS-1:0] grant_o,
  output logic [SRC_WIDTH-1:0]  idx_o,
  output logic                  any_o
);

  logic [3:0] pick;
  logic       unused_pick;

  assign pick        = rr_pick(16'(req_i), 4'(ptr_i), NUM_INPUTS);
  assign unused_pick = ^pick;
  assign idx_o       = pick[SRC_WIDTH-1:0];
  assign any_o       = |req_i;
  assign grant_o     = any_o ? (NUM_INPUTS'(1) << idx_o) : '0;

endmodule

// File: rtl/stream_rr_arbiter.sv
// Round-robin arbiter sharing one valid/ready stream between NUM_INPUTS requesters.
// Each output beat is tagged with its source index. Output passes through a
// registered two-entry stage, so o_* and every i_ready bit come from flops
// (i_ready additionally gated by the combinational grant from i_valid).
//   clk, reset_n : clock, asynchronous active-low reset
//   bus          : stream_rr_arbiter_if.slave handshake bundle
// Optional feature: define STREAM_ARB_PACKET_LOCK_EN to hold the grant on one
// requester from its first beat until its i_last beat; otherwise o_last is 0.
module stream_rr_arbiter
  import stream_arb_pkg::*;
#(
  parameter int NUM_INPUTS = 4,
  parameter int WORD_WIDTH = 8,
  parameter int SRC_WIDTH  = $clog2(NUM_INPUTS)
) (
  input logic                clk,
  input logic                reset_n,
  stream_rr_arbiter_if.slave bus
);

  stage_state_t          state_q, state_d;
  logic                  stage_ready_q, stage_ready_d;
  logic                  valid_q, valid_d;
  logic [WORD_WIDTH-1:0] out_data_q, out_data_d, buf_data_q, buf_data_d;
  logic [SRC_WIDTH-1:0]  out_src_q, out_src_d, buf_src_q, buf_src_d;
  logic                  out_last_q, out_last_d, buf_last_q, buf_last_d;
  logic [SRC_WIDTH-1:0]  rr_ptr_q, rr_ptr_d;

  logic [NUM_INPUTS-1:0] req;
  logic [NUM_INPUTS-1:0] grant;
  logic [SRC_WIDTH-1:0]  grant_idx;
  logic                  grant_any;
  logic                  accept;
  logic [WORD_WIDTH-1:0] in_data;
  logic                  in_last;

  // Grant only ever covers requesters with i_valid high, so accept needs no
  // further qualification.
  assign accept = grant_any && stage_ready_q;

`ifdef STREAM_ARB_PACKET_LOCK_EN
  logic                 locked_q, locked_d;
  logic [SRC_WIDTH-1:0] lock_idx_q, lock_idx_d;

  always_comb begin
    req = bus.i_valid;
    if (locked_q) req = bus.i_valid & (NUM_INPUTS'(1) << lock_idx_q);
  end

  always_comb begin
    in_last = 1'b0;
    for (int k = 0; k < NUM_INPUTS; k++) begin
      if (grant[k]) in_last = bus.i_last[k];
    end
  end

  always_comb begin
    locked_d   = locked_q;
    lock_idx_d = lock_idx_q;
    if (accept) begin
      locked_d   = !in_last;
      lock_idx_d = grant_idx;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      locked_q   <= 1'b0;
      lock_idx_q <= '0;
    end else begin
      locked_q   <= locked_d;
      lock_idx_q <= lock_idx_d;
    end
  end
`else
  logic unused_last;

  assign req         = bus.i_valid;
  assign in_last     = 1'b0;
  assign unused_last = ^bus.i_last;
`endif

  rr_grant #(
    .NUM_INPUTS(NUM_INPUTS),
    .SRC_WIDTH (SRC_WIDTH)
  ) u_rr_grant (
    .req_i  (req),
    .ptr_i  (rr_ptr_q),
    .grant_o(grant),
    .idx_o  (grant_idx),
    .any_o  (grant_any)
  );

  always_comb begin
    in_data = '0;
    for (int k = 0; k < NUM_INPUTS; k++) begin
      if (grant[k]) in_data = bus.i_data[k*WORD_WIDTH +: WORD_WIDTH];
    end
  end

  assign rr_ptr_d = accept ? grant_idx : rr_ptr_q;

  // Output stage: out_* is the presented entry, buf_* catches the one beat
  // that may arrive in the cycle o_ready drops.
  always_comb begin
    state_d    = state_q;
    out_data_d = out_data_q;
    out_src_d  = out_src_q;
    out_last_d = out_last_q;
    buf_data_d = buf_data_q;
    buf_src_d  = buf_src_q;
    buf_last_d = buf_last_q;
    unique case (state_q)
      EMPTY: begin
        if (accept) begin
          out_data_d = in_data;
          out_src_d  = grant_idx;
          out_last_d = in_last;
          state_d    = BUSY;
        end
      end
      BUSY: begin
        if (accept && bus.o_ready) begin
          out_data_d = in_data;
          out_src_d  = grant_idx;
          out_last_d = in_last;
        end else if (accept) begin
          buf_data_d = in_data;
          buf_src_d  = grant_idx;
          buf_last_d = in_last;
          state_d    = FULL;
        end else if (bus.o_ready) begin
          state_d = EMPTY;
        end
      end
      FULL: begin
        if (bus.o_ready) begin
          out_data_d = buf_data_q;
          out_src_d  = buf_src_q;
          out_last_d = buf_last_q;
          state_d    = BUSY;
        end
      end
      default: state_d = EMPTY;
    endcase
    stage_ready_d = (state_d != FULL);
    valid_d       = (state_d != EMPTY);
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q       <= EMPTY;
      stage_ready_q <= 1'b1;
      valid_q       <= 1'b0;
      out_data_q    <= '0;
      out_src_q     <= '0;
      out_last_q    <= 1'b0;
      buf_data_q    <= '0;
      buf_src_q     <= '0;
      buf_last_q    <= 1'b0;
      rr_ptr_q      <= SRC_WIDTH'(NUM_INPUTS - 1);
    end else begin
      state_q       <= state_d;
      stage_ready_q <= stage_ready_d;
      valid_q       <= valid_d;
      out_data_q    <= out_data_d;
      out_src_q     <= out_src_d;
      out_last_q    <= out_last_d;
      buf_data_q    <= buf_data_d;
      buf_src_q     <= buf_src_d;
      buf_last_q    <= buf_last_d;
      rr_ptr_q      <= rr_ptr_d;
    end
  end

  assign bus.i_ready  = stage_ready_q ? grant : '0;
  assign bus.o_valid  = valid_q;
  assign bus.o_data   = out_data_q;
  assign bus.o_source = out_src_q;
  assign bus.o_last   = out_last_q;

endmodule
